// File: rtl/shift_seq_unit.sv
// Sequential shifter/rotator: captures an operand and amount, then shifts up to
// STEP positions per clock until the count is exhausted, pulsing Done at the end.
module shift_seq_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Start,
  input  logic [2:0]       Mode,
  input  logic [WIDTH-1:0] A_In,
  input  logic [WIDTH-1:0] B_In,
  output logic [WIDTH-1:0] Result,
  output logic             Busy,
  output logic             Done,
  output logic             Carry,
  output logic             Zero
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam logic [SHAMT_W-1:0] STEP_C  = SHAMT_W'(STEP);
  localparam logic [SHAMT_W-1:0] ONE_C   = SHAMT_W'(1);
  localparam logic [SHAMT_W:0]   WIDTH_C = (SHAMT_W+1)'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [2:0]         mode_q, mode_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;

  logic [SHAMT_W-1:0] k;
  logic [SHAMT_W:0]   kx;
  logic [WIDTH-1:0]   rsh_last, lsh_last;
  logic               unused_b;

  assign unused_b = ^B_In[WIDTH-1:SHAMT_W];

  // Step size never overshoots the remaining count.
  assign k  = (cnt_q < STEP_C) ? cnt_q : STEP_C;
  assign kx = {1'b0, k};
  // Shifting by k-1 puts the last outgoing bit at the exit end.
  assign rsh_last = res_q >> (k - ONE_C);
  assign lsh_last = res_q << (k - ONE_C);

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          res_d   = A_In;
          cnt_d   = B_In[SHAMT_W-1:0];
          mode_d  = Mode;
          carry_d = 1'b0;
          state_d = (cnt_d == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        cnt_d = cnt_q - k;
        case (mode_q)
          3'b000: begin res_d = res_q >> k;                     carry_d = rsh_last[0];       end
          3'b001: begin res_d = $signed(res_q) >>> k;           carry_d = rsh_last[0];       end
          3'b010: begin res_d = res_q << k;                     carry_d = lsh_last[WIDTH-1]; end
          3'b011: begin res_d = (res_q >> k) | (res_q << (WIDTH_C - kx)); carry_d = rsh_last[0]; end
          3'b100: begin res_d = (res_q << k) | (res_q >> (WIDTH_C - kx)); carry_d = lsh_last[WIDTH-1]; end
          default: carry_d = 1'b0;
        endcase
        state_d = (cnt_d == '0) ? DONE : SHIFT;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Zero is captured on entry to DONE so it is valid alongside the Done pulse.
    if (state_d == DONE) zero_d = (res_d == '0);
  end

  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_q <= IDLE;
      res_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign Result = res_q;
  assign Busy   = (state_q == SHIFT);
  assign Done   = (state_q == DONE);
  assign Carry  = carry_q;
  assign Zero   = zero_q;
endmodule
